i2c_slave_controller: RTL
=========================

// Module: i2c_slave_controller
// PURPOSE
//  I2C target (slave) endpoint; the counterpart of our I2C master controller on the same bus.
//  Oversamples SCL/SDA on the system clock, detects START/STOP, matches a fixed device address and ACKs it.
//  Write transfers: delivers each received byte to user logic. Read transfers: shifts out user-supplied bytes.
//  No clock stretching; SCL is input-only; SDA is open-drain (drives 0 or Z only).
// PARAMETERS
//  ADDR_WIDTH   7       device address width
//  DATA_WIDTH   8       data byte width
//  SLAVE_ADDR   7'h50   address this target responds to (ADDR_WIDTH bits)
//  SYNC_STAGES  2       synchronizer flops on SCL/SDA inputs (>=2)
// PORTS
//  clk       in     1           system clock
//  rst_n     in     1           asynchronous active-low reset
//  i2c_scl   in     1           I2C clock line (sampled)
//  i2c_sda   inout  1           I2C data line; driven 1'b0 or 1'bz only
//  rx_data   out    DATA_WIDTH  last byte written by master
//  rx_valid  out    1           1-clk pulse: rx_data updated
//  tx_data   in     DATA_WIDTH  byte to return on read
//  tx_req    out    1           1-clk pulse: tx_data captured into the shift register on the next SCL fall
//  busy      out    1           high from address match to STOP/NACK/START
// BEHAVIOUR
//  Reset: state=IDLE, SDA released (Z), rx_data=0, rx_valid=0, tx_req=0, busy=0, bit counter=0.
//  Reset mid-transfer releases SDA within the same cycle (async) and discards the partial byte.
//  Inputs pass through SYNC_STAGES flops; edges found by comparing against a one-cycle-delayed copy.
//  Required bus timing: SCL high and low phases each >=4 clk (master CLOCK_DIV>=8).
//  START = SDA fall while SCL high; STOP = SDA rise while SCL high. Checked every clk, priority over FSM.
//  START in any state (repeated start included) -> ADDR, counter=0. STOP in any state -> IDLE, SDA released.
//  Sample SDA on SCL rise; change driven SDA only on SCL fall.
//  FSM states (shared enum):
//   IDLE:      wait for START.
//   ADDR:      shift in ADDR_WIDTH address bits + rw, MSB first. After the 8th rise: match -> ADDR_ACK, else IGNORE.
//   ADDR_ACK:  on next SCL fall drive SDA=0, hold through the 9th SCL high; busy=1.
//              rw=1: tx_req pulses on the 8th rise; at the 9th fall load tx_data and drive MSB -> READ_DATA.
//              rw=0: at the 9th fall release SDA -> WRITE_DATA.
//   WRITE_DATA: shift DATA_WIDTH bits on rises; after the last rise rx_data<=byte and rx_valid pulses the next clk -> WRITE_ACK.
//   WRITE_ACK: drive SDA=0 from the next fall to the following fall, then release -> WRITE_DATA (multi-byte).
//   READ_DATA: drive bit (0 -> low, 1 -> Z) on each fall, MSB first; after the last bit's fall-out, release at next fall -> READ_ACK.
//   READ_ACK:  sample master ACK on rise. ACK(0): tx_req pulses, load at next fall -> READ_DATA. NACK(1): -> IGNORE.
//   IGNORE:    SDA released; wait for START/STOP.
//  Counter width $clog2(DATA_WIDTH+1); it wraps to 0 at each byte boundary.
//  busy falls on STOP, NACK, non-match, or reset. rx_valid and tx_req are never high in the same cycle.
//  SDA is never driven low while a STOP/START could be misread: drive changes only occur after a detected SCL fall.
// STRUCTURE
//  i2c_pkg: i2c_slave_state_t enum (IDLE, ADDR, ADDR_ACK, WRITE_DATA, WRITE_ACK, READ_DATA, READ_ACK, IGNORE).
//  i2c_pkg: localparams for ACK=1'b0 and NACK=1'b1.
//  Sub-module i2c_line_sync: SYNC_STAGES synchronizer plus rise/fall detect for one line; instantiated for SCL and SDA.
//  Top level: START/STOP detector, FSM, shift register, bit counter, open-drain SDA output.
// TESTING (bench: i2c_master_controller CLOCK_DIV=8 + pull-up model on SDA/SCL)
//  1. Write 0x50/W, data 0xA5 -> address ACK=0, data ACK=0, rx_data=0xA5 with one rx_valid pulse, busy falls after STOP.
//  2. Read 0x50/R, tx_data=0x3C -> tx_req pulses once, master data_out=0x3C, NACK/STOP, state returns to IDLE.
//  3. Write to address 0x51 -> SDA never driven low, master sees NACK and issues STOP, no rx_valid, busy stays 0.
//  4. Two-byte write 0x11, 0x22 then a repeated START with a read returning 0x99 -> two rx_valid pulses with the matching values; read returns 0x99.
//  5. Assert rst_n low during the 4th data bit of a write -> SDA goes Z immediately, outputs return to reset values, the next transfer succeeds.
//  6. STOP injected in the middle of an address byte -> IDLE, no ACK driven, busy=0.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared types and bus constants for the I2C target endpoint.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WRITE_DATA,
    WRITE_ACK,
    READ_DATA,
    READ_ACK,
    IGNORE
  } i2c_slave_state_t;

  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

endpackage

// File: rtl/i2c_line_sync.sv
// Input synchronizer for one I2C line with rise/fall detect against a one-cycle-delayed copy.
module i2c_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic line_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], line_in};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  // Lines idle high, so reset to 1 to avoid a phantom edge after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/i2c_slave_controller.sv
// I2C target endpoint: oversampled SCL/SDA, START/STOP detect, fixed address match,
// byte receive/transmit with open-drain SDA. No clock stretching.
//
// state      | meaning
// IDLE       | wait for START
// ADDR       | shift in address + rw
// ADDR_ACK   | drive address ACK for the 9th clock
// WRITE_DATA | shift in a data byte
// WRITE_ACK  | drive data ACK for one clock
// READ_DATA  | shift out a data byte
// READ_ACK   | sample master ACK/NACK
// IGNORE     | not addressed, wait for START/STOP
module i2c_slave_controller
  import i2c_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 7,
  parameter int                    DATA_WIDTH  = 8,
  parameter logic [ADDR_WIDTH-1:0] SLAVE_ADDR  = 7'h50,
  parameter int                    SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i2c_scl,
  inout  wire                   i2c_sda,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_req,
  output logic                  busy
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;
  logic start_det, stop_det;

  i2c_slave_state_t      state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  sda_oe_q, sda_oe_d;
  logic                  rw_q, rw_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  tx_req_q, tx_req_d;
  logic                  busy_q, busy_d;

  i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_scl_sync (
    .clk(clk), .rst_n(rst_n), .line_in(i2c_scl),
    .level(scl_lvl), .rise(scl_rise), .fall(scl_fall)
  );

  i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sda_sync (
    .clk(clk), .rst_n(rst_n), .line_in(i2c_sda),
    .level(sda_lvl), .rise(sda_rise), .fall(sda_fall)
  );

  assign start_det = sda_fall & scl_lvl;
  assign stop_det  = sda_rise & scl_lvl;

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    sda_oe_d   = sda_oe_q;
    rw_d       = rw_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    tx_req_d   = 1'b0;
    busy_d     = busy_q;
    if (start_det) begin
      state_d  = ADDR;
      shift_d  = '0;
      cnt_d    = '0;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else if (stop_det) begin
      state_d  = IDLE;
      cnt_d    = '0;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else begin
      case (state_q)
        ADDR: if (scl_rise) begin
          shift_d = {shift_q[DATA_WIDTH-2:0], sda_lvl};
          if (cnt_q == CNT_W'(ADDR_WIDTH)) begin
            cnt_d = '0;
            if (shift_q[ADDR_WIDTH-1:0] == SLAVE_ADDR) begin
              state_d  = ADDR_ACK;
              busy_d   = 1'b1;
              rw_d     = sda_lvl;
              tx_req_d = sda_lvl;
            end else begin
              state_d = IGNORE;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        // sda_oe_q distinguishes the fall that starts the ACK from the one that ends it.
        ADDR_ACK: if (scl_fall) begin
          if (!sda_oe_q) begin
            sda_oe_d = 1'b1;
          end else if (rw_q) begin
            shift_d  = tx_data;
            sda_oe_d = ~tx_data[DATA_WIDTH-1];
            cnt_d    = '0;
            state_d  = READ_DATA;
          end else begin
            sda_oe_d = 1'b0;
            state_d  = WRITE_DATA;
          end
        end
        WRITE_DATA: if (scl_rise) begin
          shift_d = {shift_q[DATA_WIDTH-2:0], sda_lvl};
          if (cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
            cnt_d      = '0;
            rx_data_d  = {shift_q[DATA_WIDTH-2:0], sda_lvl};
            rx_valid_d = 1'b1;
            state_d    = WRITE_ACK;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        WRITE_ACK: if (scl_fall) begin
          if (!sda_oe_q) begin
            sda_oe_d = 1'b1;
          end else begin
            sda_oe_d = 1'b0;
            state_d  = WRITE_DATA;
          end
        end
        READ_DATA: if (scl_fall) begin
          if (cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
            cnt_d    = '0;
            sda_oe_d = 1'b0;
            state_d  = READ_ACK;
          end else begin
            shift_d  = {shift_q[DATA_WIDTH-2:0], 1'b0};
            sda_oe_d = ~shift_q[DATA_WIDTH-2];
            cnt_d    = cnt_q + 1'b1;
          end
        end
        READ_ACK: if (scl_rise) begin
          if (sda_lvl == NACK) begin
            state_d = IGNORE;
            busy_d  = 1'b0;
          end else begin
            tx_req_d = 1'b1;
          end
        end else if (scl_fall) begin
          shift_d  = tx_data;
          sda_oe_d = ~tx_data[DATA_WIDTH-1];
          cnt_d    = '0;
          state_d  = READ_DATA;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      cnt_q      <= '0;
      sda_oe_q   <= 1'b0;
      rw_q       <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      tx_req_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      sda_oe_q   <= sda_oe_d;
      rw_q       <= rw_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      tx_req_q   <= tx_req_d;
      busy_q     <= busy_d;
    end
  end

  assign i2c_sda  = sda_oe_q ? 1'b0 : 1'bz;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign tx_req   = tx_req_q;
  assign busy     = busy_q;

endmodule
